sample_timer_ctrl: RTL
======================

SAMPLE_TIMER_CTRL -- requirements
Module: sample_timer_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_PERIOD_BITS, default 8, giving the width of the bit-period configuration.
REQ-002 The block SHALL have parameter NUM_IDX_BITS, default 5, giving the width of the bit-count configuration and the bit index.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin one packet; sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: terminate the current packet immediately.
REQ-007 The block SHALL have port bit_period, input, NUM_PERIOD_BITS bits: clocks per bit (P), latched on accepted start.
REQ-008 The block SHALL have port num_bits, input, NUM_IDX_BITS bits: bits per packet (N), latched on accepted start.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port sample_strobe, output, 1 bit: one-cycle pulse at each bit sample point.
REQ-011 The block SHALL have port bit_index, output, NUM_IDX_BITS bits: zero-based index of the bit being sampled.
REQ-012 The block SHALL have port packet_done, output, 1 bit: one-cycle pulse after the last bit is sampled.
REQ-013 The block SHALL have port cfg_error, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, ALIGN, RUN and DONE.
REQ-015 In IDLE with start=1 and abort=0, if P>=2 and N>=1 the block SHALL latch P and N and enter ALIGN on the next cycle.
REQ-016 In IDLE with start=1, abort=0 and either P<2 or N=0, the block SHALL pulse cfg_error in the next cycle and remain in IDLE.
REQ-017 ALIGN SHALL last H = P>>1 cycles and then transition to RUN.
REQ-018 With start accepted at cycle 0, sample_strobe SHALL be high exactly at cycles H + k*P for k = 1..N, and low at all other cycles.
REQ-019 bit_index SHALL equal k-1 during the k-th strobe, increment in the cycle after each strobe, and read 0 in IDLE and ALIGN.
REQ-020 After the N-th strobe the block SHALL enter DONE for one cycle (cycle H + N*P + 1) with packet_done=1 and busy=1, then return to IDLE.
REQ-021 The clock counter SHALL count 1..P and wrap to 1, and the bit counter SHALL count 1..N; both SHALL be cleared on entry to ALIGN and on abort.
REQ-022 start SHALL be ignored in ALIGN, RUN and DONE.
REQ-023 Changes to bit_period and num_bits SHALL have no effect after the start is accepted.
REQ-024 abort=1 in ALIGN, RUN or DONE SHALL force IDLE on the next cycle, suppress any sample_strobe and packet_done in that cycle, and produce no later packet_done.
REQ-025 If start and abort are both 1 in IDLE, abort SHALL win: the block stays in IDLE with no cfg_error.
REQ-026 The block SHALL accept a new start in the first IDLE cycle after DONE.

Reset
REQ-027 On n_rst=0, regardless of the clock, the state SHALL be IDLE, both counters and the latched configuration SHALL be cleared, and busy, sample_strobe, packet_done, cfg_error and bit_index SHALL all be 0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet with no packet_done, and operation SHALL resume only on a fresh start.

Structure
REQ-029 A shared package SHALL hold the state enum type and the constant MIN_BIT_PERIOD = 2.
REQ-030 The clock counter and bit counter SHALL each be an instance of the team's flex_counter sub-module, with widths NUM_PERIOD_BITS and NUM_IDX_BITS respectively.
REQ-031 The FSM, latched configuration and output logic SHALL reside in sample_timer_ctrl.

Verification
REQ-032 The bench SHALL cover: P=8, N=4, start at cycle 0 -> strobes at cycles 12, 20, 28, 36 with bit_index 0..3; packet_done at cycle 37; busy high for cycles 1..37.
REQ-033 The bench SHALL cover: P=3, N=2 -> H=1; strobes at cycles 4 and 7; packet_done at cycle 8.
REQ-034 The bench SHALL cover: P=8, N=4, abort at cycle 20 -> no strobe at cycle 20; busy low from cycle 21; no packet_done.
REQ-035 The bench SHALL cover: P=1 or N=0 with start -> cfg_error pulse at cycle 1; busy stays 0.
REQ-036 The bench SHALL cover: n_rst asserted at cycle 15 mid-packet -> all outputs 0 immediately; a new start after release produces correct strobe timing.
REQ-037 The bench SHALL cover: start held high continuously, P=4, N=1 -> back-to-back packets with strobe at cycle 6 and packet_done at cycle 7, a new start accepted at cycle 8, and next strobe at cycle 14.

Source files
------------

// File: rtl/sample_timer_ctrl_pkg.sv
// Shared types and constants for the sample timer controller.
//   state_e        : controller FSM states
//   MIN_BIT_PERIOD : smallest bit period (clocks per bit) accepted on start
package sample_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int MIN_BIT_PERIOD = 2;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and programmable wrap point.
// When enabled, counts up; after reaching rollover_val it wraps to 1 (not 0),
// so a counter cleared to 0 and then enabled steps 1..rollover_val repeatedly.
//   clk          : clock, rising edge
//   n_rst        : asynchronous active-low reset (count -> 0)
//   clear        : synchronous clear to 0, wins over count_enable
//   count_enable : advance the count this cycle
//   rollover_val : last value before wrapping back to 1
//   count_out    : current count
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count_q == rollover_val) ? CNT_ONE : count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_out = count_q;

endmodule

// File: rtl/sample_timer_ctrl.sv
// Bit-sampling timer: on an accepted start it waits half a bit period (ALIGN),
// then pulses sample_strobe once per bit period for num_bits bits (RUN),
// then pulses packet_done for one cycle (DONE).
//   clk, n_rst    : clock (rising edge) and asynchronous active-low reset
//   start         : begin a packet (only looked at in IDLE)
//   abort         : drop the current packet, back to IDLE next cycle
//   bit_period    : clocks per bit P, latched on accepted start
//   num_bits      : bits per packet N, latched on accepted start
//   busy          : high in every state but IDLE
//   sample_strobe : one-cycle pulse at each bit sample point
//   bit_index     : zero-based index of the bit being sampled (0 outside RUN)
//   packet_done   : one-cycle pulse in DONE
//   cfg_error     : one-cycle pulse the cycle after a rejected start
module sample_timer_ctrl
    import sample_timer_ctrl_pkg::*;
#(
    parameter int NUM_PERIOD_BITS = 8,
    parameter int NUM_IDX_BITS    = 5
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NUM_PERIOD_BITS-1:0] bit_period,
    input  logic [NUM_IDX_BITS-1:0]    num_bits,
    output logic                       busy,
    output logic                       sample_strobe,
    output logic [NUM_IDX_BITS-1:0]    bit_index,
    output logic                       packet_done,
    output logic                       cfg_error
);

    localparam logic [NUM_PERIOD_BITS-1:0] P_ONE = NUM_PERIOD_BITS'(1);
    localparam logic [NUM_PERIOD_BITS-1:0] MIN_P = NUM_PERIOD_BITS'(MIN_BIT_PERIOD);
    localparam logic [NUM_IDX_BITS-1:0]    N_ONE = NUM_IDX_BITS'(1);

    state_e                     state_q, state_d;
    logic [NUM_PERIOD_BITS-1:0] period_q, period_d;
    logic [NUM_IDX_BITS-1:0]    nbits_q, nbits_d;
    logic                       cfg_err_q, cfg_err_d;

    logic [NUM_PERIOD_BITS-1:0] clk_cnt, clk_roll_val;
    logic [NUM_IDX_BITS-1:0]    bit_cnt;
    logic cfg_ok, accept, clk_en, clk_wrap, cnt_clear, strobe_int, last_bit;

    always_comb begin
        cfg_ok    = (bit_period >= MIN_P) && (num_bits != '0);
        accept    = (state_q == IDLE) && start && !abort && cfg_ok;
        cnt_clear = accept || abort;
        clk_en    = (state_q == ALIGN) || (state_q == RUN);
        // In ALIGN the counter runs 0..H-1 (H = P/2) and its wrap to 1 lines
        // up the first RUN cycle as count 1; in RUN it then cycles 1..P.
        clk_roll_val = (state_q == ALIGN) ? (period_q >> 1) - P_ONE : period_q;
        clk_wrap     = (clk_cnt == clk_roll_val);
        strobe_int   = (state_q == RUN) && clk_wrap && !abort;
        // bit_cnt holds the number of strobes already issued
        last_bit     = (bit_cnt == nbits_q - N_ONE);
    end

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        nbits_d   = nbits_q;
        cfg_err_d = (state_q == IDLE) && start && !abort && !cfg_ok;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = ALIGN;
                    period_d = bit_period;
                    nbits_d  = num_bits;
                end
            end
            ALIGN:   if (clk_wrap) state_d = RUN;
            RUN:     if (strobe_int && last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            period_q  <= '0;
            nbits_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            nbits_q   <= nbits_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    flex_counter #(.NUM_CNT_BITS(NUM_PERIOD_BITS)) u_clk_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (clk_en),
        .rollover_val (clk_roll_val),
        .count_out    (clk_cnt)
    );

    flex_counter #(.NUM_CNT_BITS(NUM_IDX_BITS)) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (strobe_int),
        .rollover_val (nbits_q),
        .count_out    (bit_cnt)
    );

    assign busy          = (state_q != IDLE);
    assign sample_strobe = strobe_int;
    assign packet_done   = (state_q == DONE) && !abort;
    assign bit_index     = (state_q == RUN) ? bit_cnt : '0;
    assign cfg_error     = cfg_err_q;

endmodule
